// File: rtl/pdm_tx_if.sv
// PCM sample stream into the PDM transmitter.
//   pcm_data  : signed 16-bit sample offered by the source
//   pcm_valid : pcm_data is offered this cycle
//   pcm_ready : transmitter FIFO can take a sample this cycle
// master = sample source, slave = pdm_tx.
interface pdm_tx_if;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;

    modport master (output pcm_data, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_tx.sv
// First-order sigma-delta PDM transmitter with a small PCM sample FIFO.
//   AHBclk    : sole clock, rising edge
//   rst       : synchronous active-high reset
//   ctrl      : 00 idle, 01 run, 10 flush (stop request while running), 11 as 00
//   pcm       : sample stream (pdm_tx_if.slave)
//   PDMclk    : generated bit clock, period 2*HALF_DIV AHBclk cycles
//   pdm_out   : bitstream, changes only when PDMclk falls
//   bsy       : high while running
//   underflow : sticky, a sample was needed while the FIFO was empty
module pdm_tx #(
    parameter int unsigned HALF_DIV   = 33,
    parameter int unsigned OSR        = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       AHBclk,
    input  logic       rst,
    input  logic [1:0] ctrl,
    pdm_tx_if.slave    pcm,
    output logic       PDMclk,
    output logic       pdm_out,
    output logic       bsy,
    output logic       underflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BitW = $clog2(OSR);

    localparam logic [7:0]      DivLast = 8'(HALF_DIV - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic            pdmclk_q, pdmclk_d;
    logic            pdm_q, pdm_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     cur_q, cur_d;
    logic            uf_q, uf_d;
    logic [PtrW-1:0] wr_q, wr_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            run_req, flush, push, pop, tick;
    logic [BitW-1:0] bit_use;
    logic [15:0]     sample;
    logic [16:0]     sum;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        pdmclk_d = pdmclk_q;
        pdm_d    = pdm_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        cur_d    = cur_q;
        uf_d     = uf_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        tick     = 1'b0;
        pop      = 1'b0;
        bit_use  = bit_q;
        sample   = cur_q;
        sum      = '0;

        run_req = (ctrl == 2'b01);
        // Flush only acts from IDLE; in RUN a 10 is just a stop request.
        flush   = (state_q == StIdle) && (ctrl == 2'b10);
        push    = pcm.pcm_valid && ready_q && !flush;

        unique case (state_q)
            StIdle: begin
                pdm_d    = 1'b0;
                pdmclk_d = 1'b0;
                if (run_req) begin
                    state_d  = StRun;
                    div_d    = '0;
                    tick     = 1'b1;
                    bit_use  = '0;  // every run starts a fresh frame
                end
            end
            StRun: begin
                if (div_q == DivLast) begin
                    div_d    = '0;
                    pdmclk_d = !pdmclk_q;
                    // Stop decisions are taken only on the falling toggle: no runt pulses.
                    if (pdmclk_q) begin
                        if (run_req) begin
                            tick = 1'b1;
                        end else begin
                            state_d = StIdle;
                            pdm_d   = 1'b0;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tick) begin
            if (bit_use == '0) begin
                if (cnt_q != '0) begin
                    sample = mem_q[rd_q];
                    pop    = 1'b1;
                end else begin
                    sample = '0;
                    uf_d   = 1'b1;
                end
                cur_d = sample;
            end
            // Flipping the MSB maps signed PCM to an unsigned offset; the carry is the bit.
            sum   = {1'b0, acc_q} + {1'b0, sample ^ 16'h8000};
            acc_d = sum[15:0];
            pdm_d = sum[16];
            bit_d = bit_use + 1'b1;
        end

        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            acc_d = '0;
            bit_d = '0;
            cur_d = '0;
            uf_d  = 1'b0;
        end else begin
            if (push) wr_d = (wr_q == PtrLast) ? '0 : wr_q + 1'b1;
            if (pop)  rd_d = (rd_q == PtrLast) ? '0 : rd_q + 1'b1;
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        ready_d = (cnt_d != DepthC);
    end

    always_ff @(posedge AHBclk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            pdmclk_q <= 1'b0;
            pdm_q    <= 1'b0;
            bit_q    <= '0;
            acc_q    <= '0;
            cur_q    <= '0;
            uf_q     <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            pdmclk_q <= pdmclk_d;
            pdm_q    <= pdm_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            cur_q    <= cur_d;
            uf_q     <= uf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            if (push) mem_q[wr_q] <= pcm.pcm_data;
        end
    end

    assign PDMclk        = pdmclk_q;
    assign pdm_out       = pdm_q;
    assign bsy           = (state_q == StRun);
    assign underflow     = uf_q;
    assign pcm.pcm_ready = ready_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: a reference modulator pushes expected bits into a
// scoreboard as each run is started; a monitor pops and compares on every PDMclk rise.
module tb_pdm_tx;
    localparam int unsigned HALF_DIV   = 33;
    localparam int unsigned OSR        = 64;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ctrl;
    logic       pdmclk, pdm_out, bsy, underflow;

    pdm_tx_if pcm_if ();

    pdm_tx #(
        .HALF_DIV  (HALF_DIV),
        .OSR       (OSR),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .AHBclk   (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .pcm      (pcm_if),
        .PDMclk   (pdmclk),
        .pdm_out  (pdm_out),
        .bsy      (bsy),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [15:0] fifo_m [$];
    bit   [15:0] acc_m, cur_m;
    int          bit_m;
    bit          uf_m;
    bit          exp_q [$];
    bit          seen  [$];

    function automatic void model_tick();
        bit [16:0] s;
        if (bit_m == 0) begin
            if (fifo_m.size() > 0) begin
                cur_m = fifo_m.pop_front();
            end else begin
                cur_m = '0;
                uf_m  = 1'b1;
            end
        end
        s     = {1'b0, acc_m} + {1'b0, cur_m ^ 16'h8000};
        acc_m = s[15:0];
        exp_q.push_back(s[16]);
        bit_m = (bit_m + 1) % OSR;
    endfunction

    function automatic void model_clear();
        fifo_m.delete();
        exp_q.delete();
        acc_m = '0;
        cur_m = '0;
        bit_m = 0;
        uf_m  = 1'b0;
    endfunction

    function automatic int count_ones();
        int n = 0;
        foreach (seen[i]) n += int'(seen[i]);
        return n;
    endfunction

    // Monitor: sample pdm_out at each PDMclk rise, half an AHBclk away from the edge.
    bit pclk_prev = 1'b0;
    bit have_rise = 1'b0;
    int last_rise = 0;
    int nrise     = 0;

    always @(negedge clk) begin
        if (pdmclk && !pclk_prev) begin
            seen.push_back(pdm_out);
            check_eq("sb_has_exp", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("pdm_bit", pdm_out, exp_q.pop_front());
            if (have_rise) check_eq("pdmclk_period", cyc - last_rise, 2 * HALF_DIV);
            have_rise = 1'b1;
            last_rise = cyc;
            nrise++;
        end
        if (!bsy) have_rise = 1'b0;
        pclk_prev = pdmclk;
    end

    task automatic push_sample(input logic [15:0] d);
        int t = 0;
        @(negedge clk);
        pcm_if.pcm_data  = d;
        pcm_if.pcm_valid = 1'b1;
        fifo_m.push_back(d);
        while (!pcm_if.pcm_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("push_ready", pcm_if.pcm_ready, 1);
        @(negedge clk);
        pcm_if.pcm_valid = 1'b0;
    endtask

    task automatic hold_until_accepted(input string tag);
        int t = 0;
        while (!pcm_if.pcm_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, pcm_if.pcm_ready, 1);
        @(negedge clk);
        pcm_if.pcm_valid = 1'b0;
    endtask

    task automatic do_flush(input string tag);
        @(negedge clk);
        ctrl = 2'b10;
        @(negedge clk);
        ctrl = 2'b00;
        acc_m = '0;
        cur_m = '0;
        bit_m = 0;
        uf_m  = 1'b0;
        fifo_m.delete();
        check_eq({tag, "_uf"}, underflow, 0);
        check_eq({tag, "_rdy"}, pcm_if.pcm_ready, 1);
    endtask

    // Run for exactly nbits PDM bits, then stop with stop_cmd while PDMclk is high.
    task automatic run_bits(input int nbits, input logic [1:0] stop_cmd, input string tag);
        int t;
        bit uf_first;
        bit_m = 0;
        model_tick();
        uf_first = uf_m;
        for (int i = 1; i < nbits; i++) model_tick();
        seen.delete();
        nrise = 0;
        @(negedge clk);
        ctrl = 2'b01;
        @(negedge clk);
        check_eq({tag, "_bsy"}, bsy, 1);
        check_eq({tag, "_uf_entry"}, underflow, 32'(uf_first));
        t = 0;
        while (nrise < nbits && t < (nbits + 2) * 2 * int'(HALF_DIV)) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_nbits"}, nrise, nbits);
        check_eq({tag, "_clk_hi"}, pdmclk, 1);
        ctrl = stop_cmd;
        t = 0;
        while (bsy && t < 4 * int'(HALF_DIV)) begin
            @(negedge clk);
            t++;
        end
        ctrl = 2'b00;
        check_eq({tag, "_stopped"}, bsy, 0);
        check_eq({tag, "_stop_clk"}, pdmclk, 0);
        check_eq({tag, "_stop_out"}, pdm_out, 0);
        check_eq({tag, "_sb_drained"}, exp_q.size(), 0);
        repeat (3 * HALF_DIV) @(negedge clk);
        check_eq({tag, "_idle_clk"}, pdmclk, 0);
        check_eq({tag, "_idle_out"}, pdm_out, 0);
        check_eq({tag, "_extra_bits"}, nrise, nbits);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [15:0] burst [5];

    initial begin
        int t;
        burst[0] = 16'h4000;
        burst[1] = 16'hC000;
        burst[2] = 16'h1234;
        burst[3] = 16'hF00D;
        burst[4] = 16'h0001;
        model_clear();
        rst              = 1'b1;
        ctrl             = 2'b00;
        pcm_if.pcm_valid = 1'b0;
        pcm_if.pcm_data  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_pdmclk", pdmclk, 0);
        check_eq("rst_pdm_out", pdm_out, 0);
        check_eq("rst_bsy", bsy, 0);
        check_eq("rst_uf", underflow, 0);
        check_eq("rst_ready", pcm_if.pcm_ready, 1);

        // Zero sample: 50% density, alternating from 0.
        push_sample(16'h0000);
        run_bits(OSR, 2'b00, "zero");
        check_eq("zero_ones", count_ones(), 32);
        check_eq("zero_first", seen[0], 0);
        check_eq("zero_second", seen[1], 1);

        // Full scale positive and negative; 11 must behave like 00.
        push_sample(16'h7FFF);
        run_bits(OSR, 2'b00, "pos");
        check_eq("pos_first", seen[0], 0);
        check_eq("pos_ones", count_ones(), 63);
        push_sample(16'h8000);
        run_bits(OSR, 2'b11, "neg");
        check_eq("neg_ones", count_ones(), 0);

        // Back-to-back burst of five: four fit, fifth waits for the first pop.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pcm_if.pcm_data  = burst[i];
            pcm_if.pcm_valid = 1'b1;
            fifo_m.push_back(burst[i]);
            check_eq($sformatf("burst_rdy%0d", i), pcm_if.pcm_ready, 32'(i < 4));
            if (i < 4) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_eq("burst_held", pcm_if.pcm_ready, 0);
        fork
            run_bits(5 * OSR, 2'b00, "burst");
            hold_until_accepted("burst_5th_accept");
        join
        check_eq("burst_uf", underflow, 0);

        // Flush with a simultaneous push (dropped), then underflow on an empty FIFO;
        // a 10 in RUN only stops, it must not flush while running.
        @(negedge clk);
        pcm_if.pcm_data  = 16'h1234;
        pcm_if.pcm_valid = 1'b1;
        ctrl             = 2'b10;
        @(negedge clk);
        pcm_if.pcm_valid = 1'b0;
        ctrl             = 2'b00;
        acc_m = '0;
        cur_m = '0;
        bit_m = 0;
        uf_m  = 1'b0;
        check_eq("flush_uf", underflow, 0);
        check_eq("flush_rdy", pcm_if.pcm_ready, 1);
        run_bits(10, 2'b10, "uflow");
        check_eq("uflow_sticky", underflow, 1);
        do_flush("uflow_clear");

        // Reset in the middle of a run.
        push_sample(16'h6000);
        push_sample(16'h2000);
        bit_m = 0;
        model_tick();
        model_tick();
        nrise = 0;
        @(negedge clk);
        ctrl = 2'b01;
        t = 0;
        while (nrise < 2 && t < 8 * int'(HALF_DIV)) begin
            @(negedge clk);
            t++;
        end
        check_eq("mid_nbits", nrise, 2);
        check_eq("mid_clk_hi", pdmclk, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_pdmclk", pdmclk, 0);
        check_eq("mid_rst_out", pdm_out, 0);
        check_eq("mid_rst_bsy", bsy, 0);
        check_eq("mid_rst_uf", underflow, 0);
        check_eq("mid_rst_ready", pcm_if.pcm_ready, 1);
        check_eq("mid_rst_sb", exp_q.size(), 0);
        rst  = 1'b0;
        ctrl = 2'b00;
        model_clear();

        // FIFO contents must be gone after that reset.
        run_bits(4, 2'b00, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
